// File: rtl/down_counter_timer.sv
// Loadable down-counter with a built-in prescaler, a terminal-count pulse and
// optional auto-reload. Q drives the HEX decoders directly.
module down_counter_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             C,
  input  logic             Clr,
  input  logic             Ld,
  input  logic [WIDTH-1:0] D,
  input  logic             En,
  input  logic             Rl,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RELOAD, S_DONE} state_t;

  localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rel_q, rel_d;
  logic [15:0]      pre_q, pre_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rel_d   = rel_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    if (Ld) begin
      q_d     = D;
      rel_d   = D;
      pre_d   = '0;
      state_d = (D != '0) ? S_RUN : S_IDLE;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (En) begin
            if (pre_q != PRE_LAST) begin
              pre_d = pre_q + 16'd1;
            end else begin
              pre_d = '0;
              // Zero is caught one step early so Q can never wrap.
              if (q_q == ONE) begin
                q_d     = '0;
                tc_d    = 1'b1;
                state_d = Rl ? S_RELOAD : S_DONE;
              end else begin
                q_d = q_q - ONE;
              end
            end
          end
        end
        S_RELOAD: begin
          q_d     = rel_q;
          pre_d   = '0;
          state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge C or posedge Clr) begin
    if (Clr) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      rel_q   <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rel_q   <= rel_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  assign Q    = q_q;
  assign Tc   = tc_q;
  assign Busy = (state_q == S_RUN) || (state_q == S_RELOAD);

endmodule
